// File: rtl/wb_pipe_stage.sv
// MEM/WB writeback stage: carries {rd_addr, ALUout, rd_wr, DM_data, DM_OE} to register-file writeback.
// Latency: 1 cycle from accept to o_valid when empty; sustains 1 entry/cycle while i_ready=1.
// Backpressure: SKID=1 holds up to two entries, o_ready from state only; SKID=0 holds one, o_ready = !o_valid | i_ready.
module wb_pipe_stage #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int SKID       = 1,
    parameter int FLUSH_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [DATA_W-1:0] i_ALUout,
    input  logic              i_rd_wr,
    input  logic [DATA_W-1:0] i_DM_data,
    input  logic              i_DM_OE,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic [DATA_W-1:0] o_ALUout,
    output logic              o_rd_wr,
    output logic [DATA_W-1:0] o_DM_data,
    output logic              o_DM_OE,
    output logic [1:0]        o_count
);

    typedef struct packed {
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] alu_out;
        logic              rd_wr;
        logic [DATA_W-1:0] dm_data;
        logic              dm_oe;
    } wb_t;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;
    wb_t    main_q, skid_q, in_dat;
    logic   in_fire, out_fire;
    logic   load_main, load_skid, skid_to_main, clear_pay;

    assign in_dat = '{rd_addr: i_rd_addr, alu_out: i_ALUout, rd_wr: i_rd_wr,
                      dm_data: i_DM_data, dm_oe: i_DM_OE};

    assign o_valid  = (state != EMPTY);
    assign o_ready  = (SKID != 0) ? (state != FULL) : (!o_valid || i_ready);
    assign in_fire  = i_valid && o_ready;
    assign out_fire = o_valid && i_ready;
    assign o_count  = state;

    // Write qualifiers are masked by valid so an empty stage never writes back.
    assign o_rd_addr = main_q.rd_addr;
    assign o_ALUout  = main_q.alu_out;
    assign o_DM_data = main_q.dm_data;
    assign o_rd_wr   = main_q.rd_wr && o_valid;
    assign o_DM_OE   = main_q.dm_oe && o_valid;

    // State register; reset drops every held entry immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    // Next state and register load controls; flush overrides any same-cycle accept.
    always_comb begin
        state_nxt    = state;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        clear_pay    = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
            clear_pay = (FLUSH_ZERO != 0);
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt = BUSY;
                        load_main = 1'b1;
                    end
                end
                BUSY: begin
                    if (in_fire && !out_fire && (SKID != 0)) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end else if (in_fire) begin
                        // Either a replace-in-place (out also fired) or, with
                        // SKID=0, in_fire implies out_fire via o_ready.
                        load_main = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_nxt    = BUSY;
                        skid_to_main = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Head register: fed from the input or promoted from the skid entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               main_q <= '0;
        else if (clear_pay)    main_q <= '0;
        else if (load_main)    main_q <= in_dat;
        else if (skid_to_main) main_q <= skid_q;
    end

    // Skid register: catches the entry accepted while the head is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            skid_q <= '0;
        else if (clear_pay) skid_q <= '0;
        else if (load_skid) skid_q <= in_dat;
    end

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Directed bench for wb_pipe_stage: SKID=1 instance for streaming, stall, flush and async reset;
// SKID=0 instance for the combinational ready path.
// Inputs change 1ns after the rising edge; outputs are sampled there or mid-cycle.
module tb_wb_pipe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        i_valid, i_ready;
    logic        v0, r0;
    logic [4:0]  i_rd_addr;
    logic [31:0] i_ALUout, i_DM_data;
    logic        i_rd_wr, i_DM_OE;

    logic        o_ready, o_valid, o_rd_wr, o_DM_OE;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_ALUout, o_DM_data;
    logic [1:0]  o_count;

    logic        o_ready0, o_valid0, o_rd_wr0, o_DM_OE0;
    logic [4:0]  o_rd_addr0;
    logic [31:0] o_ALUout0, o_DM_data0;
    logic [1:0]  o_count0;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    wb_pipe_stage #(.DATA_W(32), .ADDR_W(5), .SKID(1), .FLUSH_ZERO(1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .i_valid(i_valid), .o_ready(o_ready),
        .i_rd_addr(i_rd_addr), .i_ALUout(i_ALUout), .i_rd_wr(i_rd_wr),
        .i_DM_data(i_DM_data), .i_DM_OE(i_DM_OE), .o_valid(o_valid), .i_ready(i_ready),
        .o_rd_addr(o_rd_addr), .o_ALUout(o_ALUout), .o_rd_wr(o_rd_wr),
        .o_DM_data(o_DM_data), .o_DM_OE(o_DM_OE), .o_count(o_count)
    );

    wb_pipe_stage #(.DATA_W(32), .ADDR_W(5), .SKID(0), .FLUSH_ZERO(1)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush), .i_valid(v0), .o_ready(o_ready0),
        .i_rd_addr(i_rd_addr), .i_ALUout(i_ALUout), .i_rd_wr(i_rd_wr),
        .i_DM_data(i_DM_data), .i_DM_OE(i_DM_OE), .o_valid(o_valid0), .i_ready(r0),
        .o_rd_addr(o_rd_addr0), .o_ALUout(o_ALUout0), .o_rd_wr(o_rd_wr0),
        .o_DM_data(o_DM_data0), .o_DM_OE(o_DM_OE0), .o_count(o_count0)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0; v0 = 1'b0; r0 = 1'b0;
        i_rd_addr = '0; i_ALUout = '0; i_rd_wr = 1'b0; i_DM_data = '0; i_DM_OE = 1'b0;

        // Reset state
        #2;
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_count", 64'(o_count), 64'd0);
        check("rst_rdwr",  64'(o_rd_wr), 64'd0);
        check("rst_alu",   64'(o_ALUout), 64'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("post_rst_ready", 64'(o_ready), 64'd1);

        // Stream: first beat, then three back-to-back beats with no bubbles
        i_ready = 1'b1; i_valid = 1'b1; i_rd_addr = 5'd5; i_ALUout = 32'h0000_1234; i_rd_wr = 1'b1;
        tick();
        check("s0_valid", 64'(o_valid), 64'd1);
        check("s0_addr",  64'(o_rd_addr), 64'd5);
        check("s0_alu",   64'(o_ALUout), 64'h1234);
        check("s0_rdwr",  64'(o_rd_wr), 64'd1);
        check("s0_count", 64'(o_count), 64'd1);
        for (int k = 1; k < 4; k++) begin
            i_ALUout = 32'h0000_1234 + 32'(k);
            tick();
            check("s_valid", 64'(o_valid), 64'd1);
            check("s_alu",   64'(o_ALUout), 64'h1234 + 64'(k));
            check("s_count", 64'(o_count), 64'd1);
        end
        i_valid = 1'b0;
        tick();
        check("s_drain_valid", 64'(o_valid), 64'd0);
        check("s_drain_rdwr",  64'(o_rd_wr), 64'd0);

        // Back-pressure: A then B with i_ready low
        i_ready = 1'b0; i_valid = 1'b1; i_ALUout = 32'hA;
        tick();
        i_ALUout = 32'hB;
        tick();
        i_valid = 1'b0;
        check("bp_count", 64'(o_count), 64'd2);
        check("bp_ready", 64'(o_ready), 64'd0);
        check("bp_head",  64'(o_ALUout), 64'hA);
        tick();
        check("bp_hold",  64'(o_ALUout), 64'hA);
        i_ready = 1'b1;
        tick();
        check("bp_b_alu",   64'(o_ALUout), 64'hB);
        check("bp_b_valid", 64'(o_valid), 64'd1);
        check("bp_b_count", 64'(o_count), 64'd1);
        tick();
        check("bp_end_valid", 64'(o_valid), 64'd0);
        check("bp_end_ready", 64'(o_ready), 64'd1);

        // Flush while FULL with a pending C on the input
        i_ready = 1'b0; i_valid = 1'b1; i_ALUout = 32'h1A;
        tick();
        i_ALUout = 32'h1B;
        tick();
        check("fl_full", 64'(o_count), 64'd2);
        i_ALUout = 32'hC; flush = 1'b1;
        tick();
        flush = 1'b0; i_valid = 1'b0;
        check("fl_valid", 64'(o_valid), 64'd0);
        check("fl_count", 64'(o_count), 64'd0);
        check("fl_rdwr",  64'(o_rd_wr), 64'd0);
        check("fl_alu",   64'(o_ALUout), 64'd0);
        tick();
        check("fl_no_c",  64'(o_valid), 64'd0);

        // Flush while BUSY with an accept in the same cycle: the accept is dropped
        i_valid = 1'b1; i_ALUout = 32'h2D;
        tick();
        check("flb_busy", 64'(o_count), 64'd1);
        i_ALUout = 32'hC; flush = 1'b1;
        tick();
        flush = 1'b0; i_valid = 1'b0;
        check("flb_valid", 64'(o_valid), 64'd0);
        tick();
        check("flb_no_c", 64'(o_valid), 64'd0);
        check("flb_alu",  64'(o_ALUout), 64'd0);

        // Load-use payload held across a stall, consumed once
        i_ready = 1'b0; i_valid = 1'b1; i_DM_OE = 1'b1; i_DM_data = 32'hDEAD_BEEF;
        i_rd_wr = 1'b1; i_ALUout = 32'h55; i_rd_addr = 5'd9;
        tick();
        i_valid = 1'b0; i_DM_data = 32'h0; i_DM_OE = 1'b0;
        check("lu_dm",   64'(o_DM_data), 64'hDEAD_BEEF);
        check("lu_oe",   64'(o_DM_OE), 64'd1);
        tick();
        check("lu_hold_dm",   64'(o_DM_data), 64'hDEAD_BEEF);
        check("lu_hold_addr", 64'(o_rd_addr), 64'd9);
        check("lu_hold_cnt",  64'(o_count), 64'd1);
        i_ready = 1'b1;
        tick();
        check("lu_once_valid", 64'(o_valid), 64'd0);
        check("lu_once_oe",    64'(o_DM_OE), 64'd0);

        // SKID=0 instance: combinational ready and replace-in-place
        i_ready = 1'b0;
        v0 = 1'b1; r0 = 1'b0; i_ALUout = 32'h77;
        tick();
        check("s0_v", 64'(o_valid0), 64'd1);
        check("s0_ready_low", 64'(o_ready0), 64'd0);
        i_ALUout = 32'h78;
        tick();
        check("s0_stall_alu", 64'(o_ALUout0), 64'h77);
        r0 = 1'b1;
        #1;
        check("s0_ready_comb", 64'(o_ready0), 64'd1);
        tick();
        check("s0_replace_alu", 64'(o_ALUout0), 64'h78);
        check("s0_replace_cnt", 64'(o_count0), 64'd1);
        v0 = 1'b0;
        tick();
        check("s0_drain", 64'(o_valid0), 64'd0);
        check("s0_drain_cnt", 64'(o_count0), 64'd0);

        // Async reset while FULL, asserted between clock edges
        i_ready = 1'b0; i_valid = 1'b1; i_rd_wr = 1'b1; i_DM_OE = 1'b1;
        i_DM_data = 32'h1111_2222; i_ALUout = 32'h21;
        tick();
        i_ALUout = 32'h22;
        tick();
        i_valid = 1'b0;
        check("ar_full", 64'(o_count), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", 64'(o_valid), 64'd0);
        check("ar_count", 64'(o_count), 64'd0);
        check("ar_rdwr",  64'(o_rd_wr), 64'd0);
        check("ar_oe",    64'(o_DM_OE), 64'd0);
        check("ar_alu",   64'(o_ALUout), 64'd0);
        check("ar_dm",    64'(o_DM_data), 64'd0);
        check("ar_ready", 64'(o_ready), 64'd1);
        #1;
        rst = 1'b0;
        tick();
        check("ar_after", 64'(o_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/wb_pipe_stage.md
Name: wb_pipe_stage

Overview:
- Parametrised MEM/WB pipeline stage carrying the writeback payload {rd_addr, ALUout, rd_wr, DM_data, DM_OE} from the memory stage to the register-file writeback.
- Replaces the fixed-width stall-clears-register stage with a valid/ready handshake, an optional two-entry skid buffer and a separate flush.
- Supports back-pressure from a multi-cycle writeback or AXI read return without losing an instruction.

Parameters:
DATA_W  32  width of ALUout and DM_data
ADDR_W  5  width of rd_addr
SKID  1  1 = two-entry skid buffer with o_ready driven from state only; 0 = single register with combinational ready
FLUSH_ZERO  1  1 = flush and reset zero the stored payload; 0 = flush clears valid only

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
flush  in  1  synchronous kill of all held entries
i_valid  in  1  upstream payload valid
o_ready  out  1  stage can accept this cycle
i_rd_addr  in  ADDR_W  destination register
i_ALUout  in  DATA_W  ALU result
i_rd_wr  in  1  register write enable
i_DM_data  in  DATA_W  data-memory read data
i_DM_OE  in  1  select DM_data for writeback
o_valid  out  1  head entry valid
i_ready  in  1  downstream consumes head this cycle
o_rd_addr  out  ADDR_W  head rd_addr
o_ALUout  out  DATA_W  head ALUout
o_rd_wr  out  1  head rd_wr AND o_valid
o_DM_data  out  DATA_W  head DM_data
o_DM_OE  out  1  head DM_OE AND o_valid
o_count  out  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Handshake terms: in_fire = i_valid & o_ready; out_fire = o_valid & i_ready.
- Reset values: state EMPTY, o_valid=0, o_count=0, o_rd_wr=0, o_DM_OE=0, all payload registers 0 (independent of FLUSH_ZERO). o_ready=1 while rst is asserted, and remains 1 afterwards until the stage fills.
- Qualification: o_rd_wr and o_DM_OE are forced to 0 whenever o_valid=0, so no spurious writeback can occur.
- Stability: while o_valid & !i_ready, all head outputs hold stable. Entries leave in arrival order; no entry is duplicated or dropped except by flush.
- Latency: 1 cycle from in_fire to o_valid when the stage is empty. Full throughput of 1 per cycle is sustained while i_ready=1.
- SKID=1 uses a main register (head) plus a skid register.
  - o_ready = (state != FULL).
  - o_valid = (state != EMPTY).
  - o_count: EMPTY=0, BUSY=1, FULL=2.
- SKID=1 state transitions:
  - EMPTY: in_fire -> BUSY, input loads main.
  - BUSY: in_fire & !out_fire -> FULL, input loads skid.
  - BUSY: !in_fire & out_fire -> EMPTY.
  - BUSY: in_fire & out_fire -> BUSY, input loads main.
  - BUSY: neither -> hold.
  - FULL: out_fire -> BUSY, skid moves to main. in_fire cannot occur in FULL because o_ready=0.
  - FULL: !out_fire -> hold.
- SKID=0:
  - o_ready = !o_valid | i_ready (combinational path from i_ready).
  - in_fire loads the register and sets valid.
  - out_fire & !in_fire clears valid.
  - o_count = o_valid.
- flush (priority below rst, above everything else):
  - Next state EMPTY; o_valid=0 on the following cycle.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle still counts as consumed downstream.
  - Payload registers are zeroed when FLUSH_ZERO=1 and hold their previous value when FLUSH_ZERO=0. In both cases rd_wr and DM_OE outputs read 0 through qualification.
- Reset mid-operation: all entries are lost immediately and asynchronously; outputs take reset values within the same cycle.
- Widths: no arithmetic; payload is passed bit-exact.

Test Plan:
- Reset then stream: assert rst, release. Apply i_valid=1 with i_rd_addr=5, i_ALUout=0x0000_1234, i_rd_wr=1 and i_ready=1. Required: o_valid=1 next cycle with the same values and o_count=1; a 4-beat back-to-back stream emerges with no bubbles.
- Back-pressure (SKID=1): hold i_ready=0 and send A (ALUout=0xA) then B (ALUout=0xB). Required: o_count=2 and o_ready=0 after B; o_ALUout stays 0xA. Raise i_ready: A then B appear on consecutive cycles, then o_valid=0 and o_ready=1.
- Flush while FULL with i_valid=1 (ALUout=0xC): required next cycle o_valid=0, o_count=0, o_rd_wr=0; C is never output. With FLUSH_ZERO=1, o_ALUout=0.
- Load-use payload: send i_DM_OE=1, i_DM_data=0xDEAD_BEEF, i_rd_wr=1 while i_ready toggles 0,1. Required: the head is held unchanged across the stall and is consumed exactly once.
- SKID=0 build: with o_valid=1 and i_ready=0, o_ready=0. Raising i_ready in the same cycle makes o_ready=1 combinationally; a simultaneous in/out fire replaces the head with o_count staying 1.
- Async reset mid-stream: assert rst between clock edges while FULL. Required: o_valid, o_count, o_rd_wr and o_DM_OE go to 0 before the next edge and the payload reads 0.
